// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the RV32 write-back path.
package regfile_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup over the pending write-back queue: youngest valid entry
// whose destination matches the lookup address supplies the data.
module wb_fwd_match #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic [DEPTH-1:0][4:0]      ent_rd,
   input  logic [DEPTH-1:0][XLEN-1:0] ent_data,
   input  logic [DEPTH-1:0]           ent_valid,
   input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
   input  logic [4:0]                 addr,
   output logic                       hit,
   output logic [XLEN-1:0]            data
);
   import regfile_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   // Walk from oldest (head) to youngest so the last match seen wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = rd_ptr;
      if (addr != REG_ZERO) begin
         for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (ent_valid[idx] && (ent_rd[idx] == addr)) begin
               hit  = 1'b1;
               data = ent_data[idx];
            end
         end
      end
   end
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side front end of the register file: merges ALU and LSU results into a
// small FIFO drained onto the single write port, with two forwarding lookups.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       lsu_valid,
   input  logic [4:0]                 lsu_rd,
   input  logic [XLEN-1:0]            lsu_data,
   output logic                       lsu_ready,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [XLEN-1:0]            alu_data,
   output logic                       alu_ready,
   input  logic                       wb_hold,
   output logic                       we3,
   output logic [4:0]                 a3,
   output logic [XLEN-1:0]            wd3,
   input  logic [4:0]                 fwd_a1,
   input  logic [4:0]                 fwd_a2,
   output logic                       fwd_hit1,
   output logic [XLEN-1:0]            fwd_data1,
   output logic                       fwd_hit2,
   output logic [XLEN-1:0]            fwd_data2,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   import regfile_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0][4:0]      ent_rd;
   logic [DEPTH-1:0][XLEN-1:0] ent_data;
   logic [DEPTH-1:0]           ent_valid;
   logic [DEPTH-1:0]           valid_next;
   logic [PTR_W-1:0]           rd_ptr;
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           alu_ptr;
   logic [CNT_W-1:0]           free;
   logic                       lsu_nz;
   logic                       lsu_acc;
   logic                       alu_acc;

   // Space is judged before this cycle's pop; a popping slot is never reused same edge.
   assign free      = CNT_W'(DEPTH) - count;
   assign lsu_nz    = lsu_valid & (lsu_rd != REG_ZERO);
   assign lsu_ready = (free >= CNT_W'(1));
   assign alu_ready = (free >= CNT_W'(2)) | (lsu_ready & ~lsu_nz);
   assign lsu_acc   = lsu_nz & lsu_ready;
   assign alu_acc   = alu_valid & alu_ready & (alu_rd != REG_ZERO);
   assign alu_ptr   = wr_ptr + PTR_W'(lsu_acc);

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign we3   = ~empty & ~wb_hold;
   assign a3    = we3 ? ent_rd[rd_ptr]   : REG_ZERO;
   assign wd3   = we3 ? ent_data[rd_ptr] : '0;

   always_comb begin
      valid_next = ent_valid;
      if (we3)     valid_next[rd_ptr]  = 1'b0;
      if (lsu_acc) valid_next[wr_ptr]  = 1'b1;
      if (alu_acc) valid_next[alu_ptr] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (we3) rd_ptr <= rd_ptr + PTR_W'(1);
         wr_ptr    <= wr_ptr + PTR_W'(lsu_acc) + PTR_W'(alu_acc);
         count     <= count + CNT_W'(lsu_acc) + CNT_W'(alu_acc) - CNT_W'(we3);
         ent_valid <= valid_next;
      end
   end

   // Payload storage carries no reset; occupancy is tracked by ent_valid/count.
   always_ff @(posedge clk) begin
      if (lsu_acc) begin
         ent_rd[wr_ptr]   <= lsu_rd;
         ent_data[wr_ptr] <= lsu_data;
      end
      if (alu_acc) begin
         ent_rd[alu_ptr]   <= alu_rd;
         ent_data[alu_ptr] <= alu_data;
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd1 (
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .ent_valid (ent_valid),
      .rd_ptr    (rd_ptr),
      .addr      (fwd_a1),
      .hit       (fwd_hit1),
      .data      (fwd_data1)
   );

   wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd2 (
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .ent_valid (ent_valid),
      .rd_ptr    (rd_ptr),
      .addr      (fwd_a2),
      .hit       (fwd_hit2),
      .data      (fwd_data2)
   );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus randomized traffic
// against a queue-based reference model and a shadow register file.
module tb_regfile_wb_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            reset;
   logic            lsu_valid, alu_valid, wb_hold;
   logic [4:0]      lsu_rd, alu_rd, fwd_a1, fwd_a2;
   logic [XLEN-1:0] lsu_data, alu_data;
   logic            lsu_ready, alu_ready, we3, fwd_hit1, fwd_hit2, full, empty;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3, fwd_data1, fwd_data2;
   logic [CW-1:0]   count;

   int checks = 0;
   int errors = 0;

   logic [4:0]      m_rd[$];
   logic [XLEN-1:0] m_data[$];
   logic [XLEN-1:0] m_rf[32];
   logic [XLEN-1:0] d_rf[32];

   regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .wb_hold(wb_hold), .we3(we3), .a3(a3), .wd3(wd3),
      .fwd_a1(fwd_a1), .fwd_a2(fwd_a2),
      .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
      .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   function automatic int m_free();
      return DEPTH - m_rd.size();
   endfunction

   function automatic logic m_lsu_ready();
      return m_free() >= 1;
   endfunction

   function automatic logic m_alu_ready();
      return (m_free() >= 2) || ((m_free() >= 1) && !(lsu_valid && lsu_rd != 5'd0));
   endfunction

   function automatic logic m_we3();
      return (m_rd.size() != 0) && !wb_hold;
   endfunction

   function automatic logic [37:0] m_head();
      if (m_we3()) return {1'b1, m_rd[0], m_data[0]};
      return '0;
   endfunction

   function automatic logic [32:0] m_fwd(input logic [4:0] a);
      logic [32:0] r;
      r = '0;
      if (a != 5'd0)
         for (int i = 0; i < m_rd.size(); i++)
            if (m_rd[i] == a) r = {1'b1, m_data[i]};
      return r;
   endfunction

   task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic h, input logic [4:0] f1, input logic [4:0] f2);
      lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
      alu_valid = av; alu_rd = ar; alu_data = ad;
      wb_hold = h; fwd_a1 = f1; fwd_a2 = f2;
      #1;
   endtask

   // Called ~1 time unit after a falling edge with inputs settled.
   task automatic tick();
      logic la, aa, w;
      la = lsu_valid && m_lsu_ready() && lsu_rd != 5'd0;
      aa = alu_valid && m_alu_ready() && alu_rd != 5'd0;
      w  = m_we3();
      if (we3 === 1'b1) d_rf[a3] = wd3;
      @(posedge clk);
      if (w) begin
         m_rf[m_rd[0]] = m_data[0];
         void'(m_rd.pop_front());
         void'(m_data.pop_front());
      end
      if (la) begin m_rd.push_back(lsu_rd); m_data.push_back(lsu_data); end
      if (aa) begin m_rd.push_back(alu_rd); m_data.push_back(alu_data); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #2;
      checks++;
      if ({we3, a3, wd3} !== 38'd0) begin
         errors++; $display("FAIL reset_head got %h exp 0", {we3, a3, wd3});
      end
      checks++;
      if ({count, full, empty, lsu_ready, alu_ready} !== {CW'(0), 1'b0, 1'b1, 1'b1, 1'b1}) begin
         errors++; $display("FAIL reset_status got cnt=%0d f=%b e=%b lr=%b ar=%b exp cnt=0 f=0 e=1 lr=1 ar=1",
                             count, full, empty, lsu_ready, alu_ready);
      end
      checks++;
      if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== 66'd0) begin
         errors++; $display("FAIL reset_fwd got h1=%b d1=%h h2=%b d2=%h exp all 0",
                             fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_single();
      drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      checks++;
      if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", alu_ready); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
      checks++;
      if ({we3, a3, wd3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         errors++; $display("FAIL single_write got %h exp %h", {we3, a3, wd3}, {1'b1, 5'd5, 32'hDEADBEEF});
      end
      checks++;
      if ({fwd_hit1, fwd_data1} !== {1'b1, 32'hDEADBEEF}) begin
         errors++; $display("FAIL single_fwd_head got %b/%h exp 1/deadbeef", fwd_hit1, fwd_data1);
      end
      tick();
      checks++;
      if (d_rf[5] !== 32'hDEADBEEF || empty !== 1'b1) begin
         errors++; $display("FAIL single_commit got x5=%h empty=%b exp deadbeef/1", d_rf[5], empty);
      end
   endtask

   task automatic test_dual();
      drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, 0);
      checks++;
      if ({lsu_ready, alu_ready} !== 2'b11) begin
         errors++; $display("FAIL dual_ready got %b exp 11", {lsu_ready, alu_ready});
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({count, we3, a3, wd3} !== {CW'(2), 1'b1, 5'd3, 32'h11}) begin
         errors++; $display("FAIL dual_first got cnt=%0d a3=%0d wd3=%h exp cnt=2 a3=3 wd3=11", count, a3, wd3);
      end
      tick();
      checks++;
      if ({count, we3, a3, wd3} !== {CW'(1), 1'b1, 5'd4, 32'h22}) begin
         errors++; $display("FAIL dual_second got cnt=%0d a3=%0d wd3=%h exp cnt=1 a3=4 wd3=22", count, a3, wd3);
      end
      tick();
      checks++;
      if (empty !== 1'b1 || we3 !== 1'b0) begin
         errors++; $display("FAIL dual_empty got empty=%b we3=%b exp 1/0", empty, we3);
      end
   endtask

   task automatic test_full();
      logic [31:0] vals[4];
      for (int i = 0; i < 4; i++) begin
         vals[i] = $urandom;
         drive(0, 0, 0, 1, 5'(10 + i), vals[i], 1, 0, 0);
         tick();
      end
      drive(1, 5'd9, 32'h5, 1, 5'd9, 32'h6, 1, 0, 0);
      checks++;
      if ({full, lsu_ready, alu_ready, we3, count} !== {1'b1, 1'b0, 1'b0, 1'b0, CW'(4)}) begin
         errors++; $display("FAIL full_state got f=%b lr=%b ar=%b we3=%b cnt=%0d exp 1 0 0 0 4",
                             full, lsu_ready, alu_ready, we3, count);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         checks++;
         if ({count, we3, a3, wd3} !== {CW'(4 - i), 1'b1, 5'(10 + i), vals[i]}) begin
            errors++; $display("FAIL full_drain%0d got cnt=%0d a3=%0d wd3=%h exp cnt=%0d a3=%0d wd3=%h",
                                i, count, a3, wd3, 4 - i, 10 + i, vals[i]);
         end
         tick();
      end
      checks++;
      if (count !== CW'(0)) begin errors++; $display("FAIL full_final got %0d exp 0", count); end
   endtask

   task automatic test_dup();
      drive(0, 0, 0, 1, 5'd7, 32'd1, 1, 0, 0);
      tick();
      drive(0, 0, 0, 1, 5'd7, 32'd2, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd0);
      checks++;
      if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 32'd2, 1'b0, 32'd0}) begin
         errors++; $display("FAIL dup_fwd got h1=%b d1=%h h2=%b d2=%h exp 1/2/0/0",
                             fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checks++;
      if (d_rf[7] !== 32'd2) begin errors++; $display("FAIL dup_commit got x7=%h exp 2", d_rf[7]); end
   endtask

   task automatic test_rd0();
      drive(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 0);
      checks++;
      if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %b exp 1", alu_ready); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({count, we3} !== {CW'(0), 1'b0}) begin
         errors++; $display("FAIL rd0_noenq got cnt=%0d we3=%b exp 0/0", count, we3);
      end
      // Zero-destination LSU result must not consume the last free slot.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 5'(20 + i), 32'(i), 1, 0, 0);
         tick();
      end
      drive(1, 5'd0, 32'h77, 1, 5'd23, 32'h88, 1, 0, 0);
      checks++;
      if ({lsu_ready, alu_ready} !== 2'b11) begin
         errors++; $display("FAIL rd0_lsu_slot got %b exp 11", {lsu_ready, alu_ready});
      end
      drive(1, 5'd1, 32'h77, 1, 5'd23, 32'h88, 1, 0, 0);
      checks++;
      if ({lsu_ready, alu_ready} !== 2'b10) begin
         errors++; $display("FAIL rd_last_slot got %b exp 10", {lsu_ready, alu_ready});
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 5'(12 + i), $urandom, 1, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 0);
      reset = 1'b1;
      #1;
      m_rd.delete();
      m_data.delete();
      checks++;
      if ({we3, count, full, empty, fwd_hit1} !== {1'b0, CW'(0), 1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL midreset got we3=%b cnt=%0d f=%b e=%b h1=%b exp 0 0 0 1 0",
                             we3, count, full, empty, fwd_hit1);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         checks++;
         if (we3 !== 1'b0) begin errors++; $display("FAIL midreset_nowrite%0d got we3=%b exp 0", i, we3); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [37:0] eh;
      logic [32:0] ef;
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         eh = m_head();
         checks++;
         if ({we3, a3, wd3} !== eh) begin
            errors++; $display("FAIL rand_head cyc %0d got %h exp %h", c, {we3, a3, wd3}, eh);
         end
         checks++;
         if ({lsu_ready, alu_ready} !== {m_lsu_ready(), m_alu_ready()}) begin
            errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, {lsu_ready, alu_ready},
                                {m_lsu_ready(), m_alu_ready()});
         end
         checks++;
         if ({count, full, empty} !== {CW'(m_rd.size()), m_rd.size() == DEPTH, m_rd.size() == 0}) begin
            errors++; $display("FAIL rand_status cyc %0d got cnt=%0d f=%b e=%b exp cnt=%0d", c,
                                count, full, empty, m_rd.size());
         end
         ef = m_fwd(fwd_a1);
         checks++;
         if ({fwd_hit1, fwd_data1} !== ef) begin
            errors++; $display("FAIL rand_fwd1 cyc %0d got %h exp %h", c, {fwd_hit1, fwd_data1}, ef);
         end
         ef = m_fwd(fwd_a2);
         checks++;
         if ({fwd_hit2, fwd_data2} !== ef) begin
            errors++; $display("FAIL rand_fwd2 cyc %0d got %h exp %h", c, {fwd_hit2, fwd_data2}, ef);
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i <= DEPTH; i++) tick();
      for (int r = 1; r < 32; r++) begin
         checks++;
         if (d_rf[r] !== m_rf[r]) begin
            errors++; $display("FAIL rand_regfile x%0d got %h exp %h", r, d_rf[r], m_rf[r]);
         end
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_rf[r] = '0;
         d_rf[r] = '0;
      end
      test_reset();
      test_single();
      test_dual();
      test_full();
      test_dup();
      test_rd0();
      test_reset_mid();
      for (int r = 0; r < 32; r++) m_rf[r] = d_rf[r];
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
